// File: rtl/alu.sv
// alu: eight-operation arithmetic/logic unit with a registered result and
// NZCV flags. One cycle of latency and a new operation accepted every cycle.
module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP_Code,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       NZCV,
   output logic             out_valid
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_ASR = 3'b111
   } op_t;

   // N and Z come from the result itself, C and V from the operation.
   function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                             input logic c,
                                             input logic v);
      pack_flags = {r[MSB], (r == '0), c, v};
   endfunction

   logic [WIDTH:0]   sum_p0;
   logic [WIDTH:0]   diff_p0;
   logic [WIDTH-1:0] res_p0;
   logic             c_p0;
   logic             v_p0;
   logic [WIDTH-1:0] result_p1;
   logic [3:0]       nzcv_p1;
   logic             vld_p1;

   // Stage 0: combinational datapath from operands into the output registers.
   // The subtraction borrow is the extra top bit of the WIDTH+1 difference,
   // which is set exactly when A < B unsigned.
   always_comb begin
      sum_p0  = {1'b0, A} + {1'b0, B};
      diff_p0 = {1'b0, A} - {1'b0, B};
      res_p0  = '0;
      c_p0    = 1'b0;
      v_p0    = 1'b0;
      case (op_t'(OP_Code))
         OP_ADD: begin
            res_p0 = sum_p0[MSB:0];
            c_p0   = sum_p0[WIDTH];
            v_p0   = (A[MSB] == B[MSB]) && (sum_p0[MSB] != A[MSB]);
         end
         OP_SUB: begin
            res_p0 = diff_p0[MSB:0];
            c_p0   = diff_p0[WIDTH];
            v_p0   = (A[MSB] != B[MSB]) && (diff_p0[MSB] != A[MSB]);
         end
         OP_AND: res_p0 = A & B;
         OP_OR:  res_p0 = A | B;
         OP_XOR: res_p0 = A ^ B;
         OP_SHL: begin
            res_p0 = {A[MSB-1:0], 1'b0};
            c_p0   = A[MSB];
            v_p0   = A[MSB] ^ A[MSB-1];
         end
         OP_SHR: begin
            res_p0 = {1'b0, A[MSB:1]};
            c_p0   = A[0];
         end
         OP_ASR: begin
            res_p0 = {A[MSB], A[MSB:1]};
            c_p0   = A[0];
         end
         default: res_p0 = '0;
      endcase
   end

   // Stage 1: capture result and flags together on a valid beat; hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_p1 <= '0;
         nzcv_p1   <= 4'b0000;
         vld_p1    <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            result_p1 <= res_p0;
            nzcv_p1   <= pack_flags(res_p0, c_p0, v_p0);
         end
      end
   end

   assign Result    = result_p1;
   assign NZCV      = nzcv_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu with hand-computed expectations.
module tb_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] OP_Code;
   logic [7:0] Result;
   logic [3:0] NZCV;
   logic       out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   alu #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .A        (A),
      .B        (B),
      .OP_Code  (OP_Code),
      .Result   (Result),
      .NZCV     (NZCV),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one beat, let it be captured, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      in_valid = v;
      OP_Code  = op;
      A        = a;
      B        = b;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      tag;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] nzcv;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{"add_e4_a2", 3'b000, 8'hE4, 8'hA2, 8'h86, 4'b1010};
      vecs[1]  = '{"add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001};
      vecs[2]  = '{"add_0_0",   3'b000, 8'h00, 8'h00, 8'h00, 4'b0100};
      vecs[3]  = '{"sub_ff_00", 3'b001, 8'hFF, 8'h00, 8'hFF, 4'b1000};
      vecs[4]  = '{"sub_6c_ba", 3'b001, 8'h6C, 8'hBA, 8'hB2, 4'b1011};
      vecs[5]  = '{"sub_d7_ba", 3'b001, 8'hD7, 8'hBA, 8'h1D, 4'b0000};
      vecs[6]  = '{"and",       3'b010, 8'hE6, 8'h2C, 8'h24, 4'b0000};
      vecs[7]  = '{"or",        3'b011, 8'hBC, 8'h12, 8'hBE, 4'b1000};
      vecs[8]  = '{"xor",       3'b100, 8'hFF, 8'hFF, 8'h00, 4'b0100};
      vecs[9]  = '{"shl_84",    3'b101, 8'h84, 8'h5A, 8'h08, 4'b0011};
      vecs[10] = '{"shr_5d",    3'b110, 8'h5D, 8'hA5, 8'h2E, 4'b0010};
      vecs[11] = '{"asr_84",    3'b111, 8'h84, 8'h33, 8'hC2, 4'b1000};
      vecs[12] = '{"asr_ff",    3'b111, 8'hFF, 8'h00, 8'hFF, 4'b1010};

      // Reset overrides a valid beat.
      rst = 1'b1;
      step(1'b1, 3'b000, 8'hFF, 8'h01);
      check("rst_result", 32'(Result), 32'h00);
      check("rst_nzcv", 32'(NZCV), 32'h0);
      check("rst_vld", 32'(out_valid), 32'h0);

      rst = 1'b0;
      step(1'b1, 3'b000, 8'hFF, 8'h01);
      check("post_rst_result", 32'(Result), 32'h00);
      check("post_rst_nzcv", 32'(NZCV), 32'h6);
      check("post_rst_vld", 32'(out_valid), 32'h1);

      // Directed vectors, issued back to back.
      for (int i = 0; i < 13; i++) begin
         step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
         check({vecs[i].tag, "_result"}, 32'(Result), 32'(vecs[i].res));
         check({vecs[i].tag, "_nzcv"}, 32'(NZCV), 32'(vecs[i].nzcv));
         check({vecs[i].tag, "_vld"}, 32'(out_valid), 32'h1);
      end

      // Back-to-back ADD then SUB, then an idle beat with different operands.
      step(1'b1, 3'b000, 8'h7F, 8'h01);
      check("b2b_add_result", 32'(Result), 32'h80);
      check("b2b_add_nzcv", 32'(NZCV), 32'h9);
      check("b2b_add_vld", 32'(out_valid), 32'h1);
      step(1'b1, 3'b001, 8'h6C, 8'hBA);
      check("b2b_sub_result", 32'(Result), 32'hB2);
      check("b2b_sub_nzcv", 32'(NZCV), 32'hB);
      check("b2b_sub_vld", 32'(out_valid), 32'h1);
      step(1'b0, 3'b100, 8'hFF, 8'hFF);
      check("idle_result", 32'(Result), 32'hB2);
      check("idle_nzcv", 32'(NZCV), 32'hB);
      check("idle_vld", 32'(out_valid), 32'h0);
      step(1'b0, 3'b000, 8'h00, 8'h00);
      check("idle2_result", 32'(Result), 32'hB2);
      check("idle2_vld", 32'(out_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
